// File: rtl/cf_rand_gen.sv
// Fresh-mask source for the masked SKINNY S-box CF stage: a seeded 64-bit LFSR
// advanced 22 steps per clock, gated by a seed/warm-up/run controller.
module cf_rand_gen #(
  parameter int          WARMUP_CYC = 128,
  parameter int          CNT_W      = 8,
  parameter logic [63:0] ZERO_SUB   = 64'h1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed_vld,
  input  logic [63:0] seed,
  input  logic        en,
  output logic        valid,
  output logic [5:0]  r1,
  output logic [5:0]  r2,
  output logic [1:0]  rc0,
  output logic [1:0]  rc1,
  output logic [1:0]  rc2,
  output logic [1:0]  kl,
  output logic [1:0]  mn
);

  typedef enum logic [1:0] {IDLE, WARM, RUN} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WARMUP_CYC - 1);

  state_t             r_state, w_state_nxt;
  logic [63:0]        r_s, w_s_nxt, w_s_adv;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [21:0]        w_mask;

  function automatic logic [63:0] lfsr_adv(input logic [63:0] s_in);
    logic [63:0] s;
    logic        fb;
    s = s_in;
    for (int i = 0; i < 22; i++) begin
      fb = s[63] ^ s[62] ^ s[60] ^ s[59];
      s  = {s[62:0], fb};
    end
    return s;
  endfunction

  assign w_s_adv = lfsr_adv(r_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_s     <= 64'h0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A seed load overrides everything, including a concurrent en in RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_cnt_nxt   = r_cnt;
    if (seed_vld) begin
      w_s_nxt     = (seed == 64'h0) ? ZERO_SUB : seed;
      w_cnt_nxt   = '0;
      w_state_nxt = WARM;
    end else begin
      unique case (r_state)
        IDLE: ;
        WARM: begin
          w_s_nxt   = w_s_adv;
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) w_state_nxt = RUN;
        end
        RUN: if (en) w_s_nxt = w_s_adv;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign valid  = (r_state == RUN);
  assign w_mask = r_s[21:0] & {22{valid}};

  assign r1  = w_mask[5:0];
  assign r2  = w_mask[11:6];
  assign rc0 = w_mask[13:12];
  assign rc1 = w_mask[15:14];
  assign rc2 = w_mask[17:16];
  assign kl  = w_mask[19:18];
  assign mn  = w_mask[21:20];

endmodule
